stack_arbiter: RTL and testbench

//  Shares one stack instance (push/pop strobe-ack port) between two requesters, e.g. the infix-to-postfix converter and a postfix evaluator.

---
 rtl/stack_pkg.sv | 41 ++++
 rtl/rr_arbiter_2.sv | 20 ++
 rtl/stack_arbiter.sv | 158 +++++++++++++++
 tb/tb_stack_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types for the stack arbiter: FSM states, stack op codes, the
// registered grant record and the operator codes the requesters exchange.
package stack_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NUM_REQ    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

  // Operator tokens pushed by the infix/postfix requesters
  typedef enum logic [2:0] {
    OPR_NONE = 3'd0,
    OPR_ADD  = 3'd1,
    OPR_SUB  = 3'd2,
    OPR_MUL  = 3'd3,
    OPR_DIV  = 3'd4
  } opr_e;

  // Granted transaction as latched in IDLE
  typedef struct packed {
    logic idx;
    op_e  op;
    logic rej;
  } txn_t;

  function automatic logic [NUM_REQ-1:0] req_oh(input logic idx);
    req_oh      = '0;
    req_oh[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter. Masked requesters are dropped; on a tie the
// requester that the pointer does not name wins. Purely combinational.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic [1:0] m;

  assign m = req & ~mask;

  // Single request passes through; a tie goes away from the last winner
  always_comb begin
    grant = m;
    if (m == 2'b11) grant = ptr ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/stack_arbiter.sv
// Serializes two push/pop requesters onto one stack port. Tracks depth,
// rejects pop-on-empty and push-on-full locally without strobing the stack.
// Optional macro STACK_ARB_LOCK_EN adds R_LOCK so a requester can hold the
// stack across several ops (e.g. pop-then-push) without interleaving.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [1:0]            R_PUSH_STB,
  input  logic [2*DATA_W-1:0]   R_PUSH_DAT,
  input  logic [1:0]            R_POP_STB,
`ifdef STACK_ARB_LOCK_EN
  input  logic [1:0]            R_LOCK,
`endif
  output logic [1:0]            R_PUSH_ACK,
  output logic [1:0]            R_POP_ACK,
  output logic [DATA_W-1:0]     R_POP_DAT,
  output logic [1:0]            R_ERR,
  output logic                  STK_PUSH_STB,
  output logic [DATA_W-1:0]     STK_PUSH_DAT,
  output logic                  STK_POP_STB,
  input  logic [DATA_W-1:0]     STK_POP_DAT,
  input  logic                  STK_PUSH_ACK,
  input  logic                  STK_POP_ACK,
  output logic [CNT_W-1:0]      COUNT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  BUSY
);

  state_e              state;
  txn_t                txn;
  logic                rr_ptr;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  hold_mask;
  logic [NUM_REQ-1:0]  arb_mask;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic                gnt_idx;
  op_e                 sel_op;
  logic                sel_rej;
  logic [DATA_W-1:0]   sel_dat;
  logic [DATA_W-1:0]   pop_q;

  assign req     = R_PUSH_STB | R_POP_STB;
  assign EMPTY   = (COUNT == '0);
  assign FULL    = (COUNT == CNT_W'(DEPTH));
  assign BUSY    = (state != IDLE);

  // Winner decode: push beats pop for a requester asserting both
  assign gnt_idx = gnt_oh[1];
  assign sel_op  = R_PUSH_STB[gnt_idx] ? OP_PUSH : OP_POP;
  assign sel_rej = (sel_op == OP_PUSH) ? FULL : EMPTY;
  assign sel_dat = gnt_idx ? R_PUSH_DAT[DATA_W +: DATA_W] : R_PUSH_DAT[0 +: DATA_W];

`ifdef STACK_ARB_LOCK_EN
  logic lock_vld;
  logic lock_id;
  logic lock_act;

  assign lock_act = lock_vld & R_LOCK[lock_id];
  // A held lock admits only its owner and exempts it from the hold-off
  assign arb_mask = lock_act ? ~req_oh(lock_id) : hold_mask;

  // Lock is taken at grant time and released as soon as the owner drops it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
    end else if (state == IDLE && |gnt_oh) begin
      lock_vld <= R_LOCK[gnt_idx];
      lock_id  <= gnt_idx;
    end else if (lock_vld && !R_LOCK[lock_id]) begin
      lock_vld <= 1'b0;
    end
  end
`else
  assign arb_mask = hold_mask;
`endif

  rr_arbiter_2 u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .mask  (arb_mask),
    .grant (gnt_oh)
  );

  // Main FSM: grant in IDLE, strobe the stack in ISSUE, answer in RESP,
  // then one HOLD cycle for the winner to drop its strobe
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      txn          <= '{idx: 1'b0, op: OP_PUSH, rej: 1'b0};
      rr_ptr       <= 1'b1;
      hold_mask    <= '0;
      pop_q        <= '0;
      COUNT        <= '0;
      STK_PUSH_STB <= 1'b0;
      STK_POP_STB  <= 1'b0;
      STK_PUSH_DAT <= '0;
      R_PUSH_ACK   <= '0;
      R_POP_ACK    <= '0;
      R_ERR        <= '0;
      R_POP_DAT    <= '0;
    end else begin
      R_PUSH_ACK <= '0;
      R_POP_ACK  <= '0;
      R_ERR      <= '0;
      R_POP_DAT  <= '0;
      case (state)
        IDLE: begin
          hold_mask <= '0;
          if (|gnt_oh) begin
            txn <= '{idx: gnt_idx, op: sel_op, rej: sel_rej};
            if (sel_rej) begin
              state <= RESP;
            end else begin
              state        <= ISSUE;
              STK_PUSH_STB <= (sel_op == OP_PUSH);
              STK_POP_STB  <= (sel_op == OP_POP);
              if (sel_op == OP_PUSH) STK_PUSH_DAT <= sel_dat;
            end
          end
        end
        ISSUE: begin
          if (txn.op == OP_PUSH && STK_PUSH_ACK) begin
            STK_PUSH_STB <= 1'b0;
            COUNT        <= COUNT + CNT_W'(1);
            state        <= RESP;
          end else if (txn.op == OP_POP && STK_POP_ACK) begin
            STK_POP_STB  <= 1'b0;
            pop_q        <= STK_POP_DAT;
            COUNT        <= COUNT - CNT_W'(1);
            state        <= RESP;
          end
        end
        RESP: begin
          R_PUSH_ACK[txn.idx] <= (txn.op == OP_PUSH);
          R_POP_ACK[txn.idx]  <= (txn.op == OP_POP);
          R_ERR[txn.idx]      <= txn.rej;
          R_POP_DAT           <= (txn.op == OP_POP && !txn.rej) ? pop_q : '0;
          rr_ptr              <= txn.idx;
          hold_mask           <= req_oh(txn.idx);
          state               <= HOLD;
        end
        HOLD: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                CLK = 1'b0;
  logic                RST_N;
  logic [1:0]          R_PUSH_STB, R_POP_STB;
  logic [2*DATA_W-1:0] R_PUSH_DAT;
`ifdef STACK_ARB_LOCK_EN
  logic [1:0]          R_LOCK;
`endif
  logic [1:0]          R_PUSH_ACK, R_POP_ACK, R_ERR;
  logic [DATA_W-1:0]   R_POP_DAT, STK_PUSH_DAT, STK_POP_DAT;
  logic                STK_PUSH_STB, STK_POP_STB, STK_PUSH_ACK, STK_POP_ACK;
  logic [CNT_W-1:0]    COUNT;
  logic                EMPTY, FULL, BUSY;

  int nassert = 0;
  int nfail   = 0;

  always #5 CLK = ~CLK;

  stack_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .R_PUSH_STB(R_PUSH_STB), .R_PUSH_DAT(R_PUSH_DAT), .R_POP_STB(R_POP_STB),
`ifdef STACK_ARB_LOCK_EN
    .R_LOCK(R_LOCK),
`endif
    .R_PUSH_ACK(R_PUSH_ACK), .R_POP_ACK(R_POP_ACK), .R_POP_DAT(R_POP_DAT), .R_ERR(R_ERR),
    .STK_PUSH_STB(STK_PUSH_STB), .STK_PUSH_DAT(STK_PUSH_DAT), .STK_POP_STB(STK_POP_STB),
    .STK_POP_DAT(STK_POP_DAT), .STK_PUSH_ACK(STK_PUSH_ACK), .STK_POP_ACK(STK_POP_ACK),
    .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL), .BUSY(BUSY)
  );

  // Behavioural stack with programmable ack delay (ack in the ack_dly-th strobe cycle)
  int                ack_dly = 1;
  int                wcnt;
  int                sp;
  logic [DATA_W-1:0] mem [0:15];
  logic [DATA_W-1:0] push_log [0:63];
  int                stk_push_n = 0;
  int                push_cyc = 0, pop_cyc = 0, both_cnt = 0;

  assign STK_PUSH_ACK = STK_PUSH_STB && (wcnt == ack_dly - 1);
  assign STK_POP_ACK  = STK_POP_STB  && (wcnt == ack_dly - 1);
  assign STK_POP_DAT  = (sp > 0) ? mem[sp-1] : '0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wcnt <= 0;
      sp   <= 0;
    end else begin
      if ((STK_PUSH_STB || STK_POP_STB) && !(STK_PUSH_ACK || STK_POP_ACK)) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (STK_PUSH_ACK && sp < 16) begin
        mem[sp] <= STK_PUSH_DAT;
        sp      <= sp + 1;
        if (stk_push_n < 64) push_log[stk_push_n] <= STK_PUSH_DAT;
        stk_push_n <= stk_push_n + 1;
      end else if (STK_POP_ACK && sp > 0) begin
        sp <= sp - 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (STK_PUSH_STB) push_cyc <= push_cyc + 1;
    if (STK_POP_STB)  pop_cyc  <= pop_cyc + 1;
    if (STK_PUSH_STB && STK_POP_STB) both_cnt <= both_cnt + 1;
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle2();
    tick(); tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One op from requester r; returns pop data, error flag and ack latency in edges
  task automatic do_op(input bit r, input bit push, input logic [31:0] d,
                       output logic [31:0] pd, output logic err, output int lat);
    bit done = 0;
    lat = 0; pd = '0; err = 1'b0;
    if (push) begin
      R_PUSH_DAT[r*DATA_W +: DATA_W] = d;
      R_PUSH_STB[r] = 1'b1;
    end else begin
      R_POP_STB[r] = 1'b1;
    end
    for (int i = 1; i <= 60 && !done; i++) begin
      tick();
      if ((push && R_PUSH_ACK[r]) || (!push && R_POP_ACK[r])) begin
        done = 1; lat = i; pd = R_POP_DAT; err = R_ERR[r];
      end
    end
    R_PUSH_STB[r] = 1'b0;
    R_POP_STB[r]  = 1'b0;
    chk("op_done", 64'(done), 64'd1);
  endtask

  // Both requesters push together; reports the ack order
  task automatic both_push(input logic [31:0] d0, input logic [31:0] d1,
                           output int first, output int second);
    int n = 0;
    first = -1; second = -1;
    R_PUSH_DAT = {d1, d0};
    R_PUSH_STB = 2'b11;
    for (int i = 0; i < 60 && n < 2; i++) begin
      tick();
      for (int r = 0; r < 2; r++) begin
        if (R_PUSH_STB[r] && R_PUSH_ACK[r]) begin
          if (n == 0) first = r; else second = r;
          n++;
          R_PUSH_STB[r] = 1'b0;
        end
      end
    end
    R_PUSH_STB = 2'b00;
    chk("both_done", 64'(n), 64'd2);
  endtask

  logic [31:0] pd;
  logic        err;
  int          lat, f, s, base, cyc0;
`ifdef STACK_ARB_LOCK_EN
  int          early0;
  bit          got;
`endif

  initial begin
    R_PUSH_STB = '0; R_POP_STB = '0; R_PUSH_DAT = '0; RST_N = 1'b0;
`ifdef STACK_ARB_LOCK_EN
    R_LOCK = '0;
`endif
    repeat (3) tick();

    // Reset state
    chk("rst_acks",  {R_PUSH_ACK, R_POP_ACK, R_ERR}, 0);
    chk("rst_stk",   {STK_PUSH_STB, STK_POP_STB}, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full",  FULL, 0);
    chk("rst_busy",  BUSY, 0);
    chk("rst_pdat",  R_POP_DAT, 0);
    RST_N = 1'b1;
    idle2();

    // Push 3, push 4, pop, pop from requester 0
    base = stk_push_n;
    do_op(1'b0, 1'b1, 32'd3, pd, err, lat);
    chk("p3_lat", lat, 3); chk("p3_err", err, 0); chk("p3_cnt", COUNT, 1);
    idle2();
    do_op(1'b0, 1'b1, 32'd4, pd, err, lat);
    chk("p4_cnt", COUNT, 2); chk("p4_full", FULL, 1);
    idle2();
    do_op(1'b0, 1'b0, 32'd0, pd, err, lat);
    chk("pop1_dat", pd, 4); chk("pop1_cnt", COUNT, 1);
    idle2();
    do_op(1'b0, 1'b0, 32'd0, pd, err, lat);
    chk("pop2_dat", pd, 3); chk("pop2_cnt", COUNT, 0); chk("pop2_empty", EMPTY, 1);
    idle2();
    chk("stk_npush", stk_push_n - base, 2);
    chk("stk_push0", push_log[base], 3);
    chk("stk_push1", push_log[base+1], 4);

    // Pop on empty is rejected locally
    cyc0 = pop_cyc;
    do_op(1'b0, 1'b0, 32'd0, pd, err, lat);
    chk("pe_lat", lat, 2); chk("pe_err", err, 1); chk("pe_dat", pd, 0);
    chk("pe_cnt", COUNT, 0); chk("pe_nostb", pop_cyc - cyc0, 0);
    idle2();

    // Push on full is rejected locally
    base = stk_push_n;
    do_op(1'b0, 1'b1, 32'd1, pd, err, lat); chk("f1_err", err, 0); idle2();
    do_op(1'b0, 1'b1, 32'd2, pd, err, lat); chk("f2_err", err, 0); idle2();
    do_op(1'b0, 1'b1, 32'd3, pd, err, lat);
    chk("f3_err", err, 1); chk("f3_lat", lat, 2); chk("f3_cnt", COUNT, 2);
    chk("f3_npush", stk_push_n - base, 2);
    idle2();
    do_op(1'b0, 1'b0, 32'd0, pd, err, lat); chk("fp1_dat", pd, 2); idle2();
    do_op(1'b0, 1'b0, 32'd0, pd, err, lat); chk("fp2_dat", pd, 1); idle2();

    // Round robin from reset: requester 0 first, then 1
    RST_N = 1'b0; tick(); RST_N = 1'b1; idle2();
    both_push(32'd10, 32'd20, f, s);
    chk("rr1_first", f, 0); chk("rr1_second", s, 1); chk("rr1_cnt", COUNT, 2);
    idle2();
    do_op(1'b0, 1'b0, 32'd0, pd, err, lat); chk("rr1_pop1", pd, 20); idle2();
    do_op(1'b0, 1'b0, 32'd0, pd, err, lat); chk("rr1_pop2", pd, 10); idle2();
    // Last winner is requester 0, so requester 1 takes the tie
    both_push(32'd30, 32'd40, f, s);
    chk("rr2_first", f, 1); chk("rr2_second", s, 0);
    idle2();
    do_op(1'b1, 1'b0, 32'd0, pd, err, lat); chk("rr2_pop1", pd, 30); idle2();
    do_op(1'b1, 1'b0, 32'd0, pd, err, lat); chk("rr2_pop2", pd, 40); idle2();

    // Slow stack: strobe held for the whole ack delay
    ack_dly = 5;
    cyc0 = push_cyc;
    do_op(1'b0, 1'b1, 32'd7, pd, err, lat);
    chk("dly_lat", lat, 7); chk("dly_stb", push_cyc - cyc0, 5); chk("dly_cnt", COUNT, 1);
    idle2();

    // Reset in the middle of ISSUE
    ack_dly = 20;
    R_PUSH_DAT[0 +: DATA_W] = 32'd9;
    R_PUSH_STB[0] = 1'b1;
    tick(); tick(); tick();
    chk("mid_stb_pre", STK_PUSH_STB, 1);
    chk("mid_busy_pre", BUSY, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_stb", {STK_PUSH_STB, STK_POP_STB}, 0);
    chk("mid_cnt", COUNT, 0);
    chk("mid_empty", EMPTY, 1);
    chk("mid_busy", BUSY, 0);
    R_PUSH_STB = '0;
    tick(); RST_N = 1'b1; ack_dly = 1; idle2();

`ifdef STACK_ARB_LOCK_EN
    // Requester 1 locks and does push/pop/push while requester 0 waits
    early0 = 0;
    R_LOCK = 2'b10;
    R_PUSH_DAT[DATA_W +: DATA_W] = 32'd5; R_PUSH_STB[1] = 1'b1;
    tick();
    R_PUSH_DAT[0 +: DATA_W] = 32'd6; R_PUSH_STB[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (R_PUSH_ACK[0]) early0++;
      if (R_PUSH_ACK[1]) got = 1;
    end
    chk("lk_push1", 64'(got), 1);
    R_PUSH_STB[1] = 1'b0; R_POP_STB[1] = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (R_PUSH_ACK[0]) early0++;
      if (R_POP_ACK[1]) begin got = 1; pd = R_POP_DAT; end
    end
    chk("lk_pop", 64'(got), 1); chk("lk_pop_dat", pd, 5);
    R_POP_STB[1] = 1'b0;
    R_PUSH_DAT[DATA_W +: DATA_W] = 32'd8; R_PUSH_STB[1] = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (R_PUSH_ACK[0]) early0++;
      if (R_PUSH_ACK[1]) got = 1;
    end
    chk("lk_push2", 64'(got), 1);
    R_PUSH_STB[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (R_PUSH_ACK[0]) early0++;
    end
    chk("lk_early0", early0, 0);
    R_LOCK = 2'b00;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (R_PUSH_ACK[0]) got = 1;
    end
    R_PUSH_STB[0] = 1'b0;
    chk("lk_req0", 64'(got), 1);
    chk("lk_cnt", COUNT, 2);
    idle2();
`endif

    chk("one_stb", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
